// File: rtl/dct_coeff_accum.sv
// dct_coeff_accum: computes one 8x8 DCT coefficient by walking all 64 pixels,
// multiplying each by an externally supplied cosine weight and accumulating.
// Three-stage datapath: weight capture, multiply, accumulate; the result is
// rounded, scaled by 2^-FRAC and saturated to 32 bits before the handshake.
module dct_coeff_accum #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic [2:0]              n1,
    output logic [2:0]              n2,
    output logic [5:0]              pix_addr,
    input  logic [PIX_W-1:0]        pix_data,
    input  logic signed [31:0]      cos_term,
    output logic signed [31:0]      coeff,
    output logic                    coeff_valid,
    input  logic                    coeff_ready
);

    localparam int unsigned PROD_W = PIX_W + 32;
    localparam int unsigned ACC_W  = 48;

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = 48'sh0000_7fff_ffff;
    localparam logic signed [ACC_W-1:0] SAT_MIN = 48'shffff_8000_0000;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                    state_q;
    logic [5:0]                idx_q;
    logic [1:0]                drain_q;

    logic signed [31:0]        cos_q;
    logic                      s1_v_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic                      s2_v_q;
    logic signed [ACC_W-1:0]   acc_q;

    logic signed [PROD_W-1:0]  pix_ext;
    logic signed [PROD_W-1:0]  cos_ext;
    logic signed [PROD_W-1:0]  prod_d;
    logic signed [ACC_W-1:0]   prod_acc;
    logic signed [ACC_W-1:0]   acc_rnd;
    logic signed [ACC_W-1:0]   acc_sh;
    logic signed [31:0]        coeff_sat;

    // Address/index outputs: only driven while walking the block
    always_comb begin
        busy = (state_q != StIdle);
        n1   = 3'd0;
        n2   = 3'd0;
        if (state_q == StRun) begin
            n1 = idx_q[5:3];
            n2 = idx_q[2:0];
        end
        pix_addr = {n1, n2};
    end

    // Multiply operands widened so the true product fits without overflow
    always_comb begin
        pix_ext  = {32'b0, pix_data};
        cos_ext  = {{PIX_W{cos_q[31]}}, cos_q};
        prod_d   = pix_ext * cos_ext;
        prod_acc = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
    end

    // Round half-up, rescale, then clamp to the 32-bit signed range
    always_comb begin
        acc_rnd = acc_q + RND;
        acc_sh  = acc_rnd >>> FRAC;
        if (acc_sh > SAT_MAX) begin
            coeff_sat = 32'sh7fff_ffff;
        end else if (acc_sh < SAT_MIN) begin
            coeff_sat = 32'sh8000_0000;
        end else begin
            coeff_sat = acc_sh[31:0];
        end
    end

    // Control FSM with registered result/handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= 6'd0;
            drain_q     <= 2'd0;
            coeff       <= 32'sd0;
            coeff_valid <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        idx_q   <= 6'd0;
                    end
                end
                StRun: begin
                    idx_q <= idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        state_q <= StDrain;
                        drain_q <= 2'd0;
                    end
                end
                StDrain: begin
                    // Three cycles: the last sample needs capture, multiply, add
                    if (drain_q == 2'd2) begin
                        state_q     <= StDone;
                        coeff       <= coeff_sat;
                        coeff_valid <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                StDone: begin
                    if (coeff_ready) begin
                        state_q     <= StIdle;
                        coeff_valid <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Datapath pipeline; valid bits keep idle-time garbage out of the sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cos_q  <= 32'sd0;
            s1_v_q <= 1'b0;
            prod_q <= '0;
            s2_v_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            cos_q  <= cos_term;
            s1_v_q <= (state_q == StRun);
            prod_q <= prod_d;
            s2_v_q <= s1_v_q;
            if ((state_q == StIdle) && start) begin
                acc_q <= '0;
            end else if (s2_v_q) begin
                acc_q <= acc_q + prod_acc;
            end
        end
    end

endmodule

// File: tb/tb_dct_coeff_accum.sv
// Directed bench for dct_coeff_accum: synchronous-read pixel RAM model and
// the k1=2, k2=6 cosine table (scaled by 256, truncated toward zero).
module tb_dct_coeff_accum;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               busy;
    logic [2:0]         n1;
    logic [2:0]         n2;
    logic [5:0]         pix_addr;
    logic [7:0]         pix_data;
    logic signed [31:0] cos_term;
    logic signed [31:0] coeff;
    logic               coeff_valid;
    logic               coeff_ready;

    logic [7:0] pix_mem [64];
    int         cos_tab [64];
    int         total = 0;
    int         bad   = 0;
    logic       saw_valid;

    localparam real PI = 3.14159265358979323846;

    always #5 clk = ~clk;

    dct_coeff_accum #(.PIX_W(8), .FRAC(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .n1          (n1),
        .n2          (n2),
        .pix_addr    (pix_addr),
        .pix_data    (pix_data),
        .cos_term    (cos_term),
        .coeff       (coeff),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready)
    );

    always @(posedge clk) pix_data <= pix_mem[pix_addr];
    assign cos_term = cos_tab[pix_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 64; i++) pix_mem[i] = v;
    endtask

    // Start at a negedge; the following posedge is E0
    task automatic run_coeff(input string tag, input logic [31:0] exp);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " busy@E0"}, 32'(busy), 32'd1);
        repeat (9) @(posedge clk);
        #1;
        check({tag, " pix_addr@idx9"}, 32'(pix_addr), 32'd9);
        check({tag, " n1n2@idx9"}, {26'd0, n1, n2}, {26'd0, 3'd1, 3'd1});
        repeat (57) @(posedge clk);
        #1;
        check({tag, " valid@E0+66"}, 32'(coeff_valid), 32'd0);
        check({tag, " pix_addr in drain"}, 32'(pix_addr), 32'd0);
        @(posedge clk);
        #1;
        check({tag, " valid@E0+67"}, 32'(coeff_valid), 32'd1);
        check({tag, " coeff"}, coeff, exp);
        check({tag, " busy in done"}, 32'(busy), 32'd1);
    endtask

    task automatic handshake(input string tag, input logic [31:0] exp);
        coeff_ready = 1'b1;
        @(posedge clk);
        #1;
        coeff_ready = 1'b0;
        check({tag, " valid after ready"}, 32'(coeff_valid), 32'd0);
        check({tag, " busy after ready"}, 32'(busy), 32'd0);
        check({tag, " coeff kept"}, coeff, exp);
    endtask

    initial begin
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                real ca, cb;
                ca = $cos(real'(2 * a + 1) * 2.0 * PI / 16.0);
                cb = $cos(real'(2 * b + 1) * 6.0 * PI / 16.0);
                cos_tab[a * 8 + b] = $rtoi(256.0 * ca * cb);
            end
        end
        fill(8'd0);
        rst         = 1'b1;
        start       = 1'b0;
        coeff_ready = 1'b0;

        // Reset values before any clock edge: proves asynchronous reset
        #3;
        check("reset busy", 32'(busy), 32'd0);
        check("reset valid", 32'(coeff_valid), 32'd0);
        check("reset coeff", coeff, 32'd0);
        check("reset pix_addr", 32'(pix_addr), 32'd0);
        check("table[0]", cos_tab[0], 32'd90);
        check("table[1]", cos_tab[1], -32'sd218);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        fill(8'd0);
        run_coeff("zeros", 32'd0);
        handshake("zeros", 32'd0);

        fill(8'd255);
        run_coeff("all255", 32'd0);
        handshake("all255", 32'd0);

        fill(8'd0);
        pix_mem[0] = 8'd100;
        run_coeff("pix0", 32'd35);
        handshake("pix0", 32'd35);

        fill(8'd0);
        pix_mem[1] = 8'd200;
        run_coeff("pix1", -32'sd170);

        // Stall in DONE with a stray start pulse
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            @(posedge clk);
            #1;
            check("stall valid", 32'(coeff_valid), 32'd1);
            check("stall coeff", coeff, -32'sd170);
        end
        check("stall pix_addr", 32'(pix_addr), 32'd0);
        // start coincident with the completing handshake must be ignored
        start       = 1'b1;
        coeff_ready = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        coeff_ready = 1'b0;
        check("hs valid low", 32'(coeff_valid), 32'd0);
        check("hs start ignored", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("still idle", 32'(busy), 32'd0);
        check("coeff held", coeff, -32'sd170);

        // Reset in the middle of RUN
        fill(8'd0);
        pix_mem[0] = 8'd100;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("idx30 pix_addr", 32'(pix_addr), 32'd30);
        rst = 1'b1;
        #1;
        check("midrun rst busy", 32'(busy), 32'd0);
        check("midrun rst pix_addr", 32'(pix_addr), 32'd0);
        check("midrun rst coeff", coeff, 32'd0);
        check("midrun rst valid", 32'(coeff_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (coeff_valid) saw_valid = 1'b1;
        end
        check("no valid after rst", 32'(saw_valid), 32'd0);
        run_coeff("post-rst", 32'd35);
        handshake("post-rst", 32'd35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a stuck simulation
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dct_coeff_accum.md
DCT_COEFF_ACCUM -- requirements
Module: dct_coeff_accum

Interface
REQ-001 SHALL have parameter PIX_W, default 8, unsigned pixel width.
REQ-002 SHALL have parameter FRAC, default 8, fractional bits of cos_term (scale 2^8).
REQ-003 SHALL have port clk  in  1  sole clock, all flops rising-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  request one 8x8 coefficient computation.
REQ-006 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-007 SHALL have ports n1 and n2  out  3 each  row/column index driven to the cosine LUT and pixel buffer.
REQ-008 SHALL have port pix_addr  out  6  equal to {n1,n2}, read address of the pixel buffer.
REQ-009 SHALL have port pix_data  in  PIX_W  unsigned pixel, valid one cycle after pix_addr is presented (synchronous-read buffer).
REQ-010 SHALL have port cos_term  in  32  signed cosine weight, combinational function of n1,n2 in the same cycle.
REQ-011 SHALL have port coeff  out  32  signed result coefficient.
REQ-012 SHALL have port coeff_valid  out  1  coeff valid; coeff_ready  in  1  consumer accepts.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE: start=1 at edge E0 -> RUN, 6-bit index idx cleared to 0, accumulator cleared to 0.
REQ-015 RUN: n1=idx[5:3], n2=idx[2:0]; idx increments each cycle; after idx=63 is presented -> DRAIN.
REQ-016 In IDLE, DRAIN, DONE, n1, n2, pix_addr SHALL be 0.
REQ-017 Pipeline: edge E+1 registers cos_term with pix_data arrival; edge E+2 registers product pix_data(zero-extended) x cos_q (signed, 40 bits); edge E+3 adds product to 48-bit signed accumulator.
REQ-018 DRAIN SHALL last exactly 3 cycles to flush the pipeline, then -> DONE.
REQ-019 On DONE entry coeff SHALL be loaded with (acc + 2^(FRAC-1)) arithmetically shifted right FRAC, saturated to [-2^31, 2^31-1]; coeff_valid rises at edge E0+67.
REQ-020 DONE: coeff and coeff_valid SHALL hold stable until coeff_ready=1 sampled, then -> IDLE with coeff_valid=0 next cycle; coeff keeps last value.
REQ-021 start SHALL be ignored in RUN, DRAIN, DONE, including the cycle where the DONE handshake completes.
REQ-022 coeff_ready outside DONE SHALL have no effect.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, idx=0, accumulator=0, all pipeline registers=0, coeff=0, coeff_valid=0, busy=0, n1=n2=pix_addr=0.
REQ-024 Reset mid-RUN/DRAIN/DONE SHALL discard the computation; no coeff_valid pulse produced for it.
REQ-025 First start after rst deassertion SHALL behave identically to any other start.

Verification (bench models 1-cycle pixel RAM and team k1=2,k2=6 cosine table)
REQ-026 All 64 pixels 0, start -> coeff_valid at E0+67, coeff=0, busy high E0..handshake.
REQ-027 All 64 pixels 255 -> coeff=0 (each table row sums to zero).
REQ-028 Pixel[0]=100, rest 0 (cos 0x05a) -> coeff=(9000+128)>>>8=35.
REQ-029 Pixel[1]=200, rest 0 (cos -0x0da) -> coeff=(-43600+128)>>>8=-170.
REQ-030 coeff_ready low 10 cycles in DONE with start pulsed -> coeff/coeff_valid stable, start ignored; ready=1 -> IDLE, valid low next cycle.
REQ-031 rst asserted at idx=30 -> all outputs 0 asynchronously, no valid; subsequent start on REQ-028 data -> coeff=35.
